lstm_init_packer: RTL and testbench

Upstream initialisation stage for the LSTM core. Accepts the serial 8-bit weight/bias stream from the host and packs it into 256-bit weight words and 16-bit bias words. Writes those words into the weight BRAM (256x2048) and bias BRAM (16x512) that the LSTM core later reads during SYSTEM/BRANCH processing. Signals completion so the core may leave initialisation.

---
 rtl/lstm_init_packer.sv | 171 +++++++++++++++++
 tb/tb_lstm_init_packer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_init_packer.sv
// lstm_init_packer: packs the host's serial 8-bit init stream into 256-bit weight and 16-bit bias BRAM writes.
// Optional trailing 16-bit checksum stage is enabled by defining LSTM_INIT_CHECKSUM_EN.
module lstm_init_packer #(
  parameter int WEIGHT_DEPTH = 2048,
  parameter int BIAS_DEPTH   = 512
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         iStart,
  input  logic         iInit_valid,
  input  logic [7:0]   iInit_data,
  output logic         oInit_ready,
  output logic         oWeight_we,
  output logic [10:0]  oWeight_addr,
  output logic [255:0] oWeight_wdata,
  output logic         oBias_we,
  output logic [8:0]   oBias_addr,
  output logic [15:0]  oBias_wdata,
  output logic         oInit_done,
  output logic         oError
);

  localparam logic [10:0] W_LAST = 11'(WEIGHT_DEPTH - 1);
  localparam logic [8:0]  B_LAST = 9'(BIAS_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WEIGHT, BIAS, CHECK, DONE, ERROR} state_t;

  state_t       state;
  logic [4:0]   byteCnt;
  logic [10:0]  wAddr;
  logic [8:0]   bAddr;
  logic [255:0] pack;
  logic [255:0] packNext;
  logic         accept;
`ifdef LSTM_INIT_CHECKSUM_EN
  logic [15:0]  sum;
`else
  assign oError = 1'b0;
`endif

  assign accept = iInit_valid && oInit_ready;

  // Packing buffer with the incoming byte merged into its lane; the final
  // byte of a word is written straight from here without an extra cycle.
  always_comb begin
    packNext = pack;
    packNext[{byteCnt, 3'b000} +: 8] = iInit_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      oInit_ready   <= 1'b0;
      oWeight_we    <= 1'b0;
      oWeight_addr  <= '0;
      oWeight_wdata <= '0;
      oBias_we      <= 1'b0;
      oBias_addr    <= '0;
      oBias_wdata   <= '0;
      oInit_done    <= 1'b0;
      byteCnt       <= '0;
      wAddr         <= '0;
      bAddr         <= '0;
      pack          <= '0;
`ifdef LSTM_INIT_CHECKSUM_EN
      oError        <= 1'b0;
      sum           <= '0;
`endif
    end else begin
      oWeight_we <= 1'b0;
      oBias_we   <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (iStart) begin
            state       <= WEIGHT;
            oInit_ready <= 1'b1;
            oInit_done  <= 1'b0;
            byteCnt     <= '0;
            wAddr       <= '0;
            bAddr       <= '0;
            pack        <= '0;
`ifdef LSTM_INIT_CHECKSUM_EN
            oError      <= 1'b0;
            sum         <= '0;
`endif
          end
        end

        WEIGHT: begin
          if (accept) begin
`ifdef LSTM_INIT_CHECKSUM_EN
            sum <= sum + 16'(iInit_data);
`endif
            if (byteCnt == 5'd31) begin
              oWeight_we    <= 1'b1;
              oWeight_addr  <= wAddr;
              oWeight_wdata <= packNext;
              pack          <= '0;
              byteCnt       <= '0;
              if (wAddr == W_LAST) begin
                state <= BIAS;
              end else begin
                wAddr <= wAddr + 1'b1;
              end
            end else begin
              pack    <= packNext;
              byteCnt <= byteCnt + 1'b1;
            end
          end
        end

        BIAS: begin
          if (accept) begin
`ifdef LSTM_INIT_CHECKSUM_EN
            sum <= sum + 16'(iInit_data);
`endif
            if (byteCnt[0]) begin
              oBias_we    <= 1'b1;
              oBias_addr  <= bAddr;
              oBias_wdata <= packNext[15:0];
              pack        <= '0;
              byteCnt     <= '0;
              if (bAddr == B_LAST) begin
`ifdef LSTM_INIT_CHECKSUM_EN
                state       <= CHECK;
`else
                state       <= DONE;
                oInit_ready <= 1'b0;
                oInit_done  <= 1'b1;
`endif
              end else begin
                bAddr <= bAddr + 1'b1;
              end
            end else begin
              pack    <= packNext;
              byteCnt <= byteCnt + 1'b1;
            end
          end
        end

`ifdef LSTM_INIT_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (!byteCnt[0]) begin
              pack    <= packNext;
              byteCnt <= 5'd1;
            end else begin
              pack        <= '0;
              byteCnt     <= '0;
              oInit_ready <= 1'b0;
              if (packNext[15:0] == sum) begin
                state      <= DONE;
                oInit_done <= 1'b1;
              end else begin
                state  <= ERROR;
                oError <= 1'b1;
              end
            end
          end
        end
`endif

        default: begin
          state       <= IDLE;
          oInit_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_init_packer.sv
// Self-checking bench for lstm_init_packer: small-depth instance for scenarios, default-depth instance for a full load.
// Checksum scenarios are compiled in when LSTM_INIT_CHECKSUM_EN is defined.
module tb_lstm_init_packer;

  localparam int WD     = 2;
  localparam int BD     = 2;
  localparam int NB     = 32 * WD + 2 * BD;
  localparam int BIG_NB = 32 * 2048 + 2 * 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         start = 1'b0, valid = 1'b0;
  logic [7:0]   data = '0;
  logic         ready, wWe, bWe, done, err;
  logic [10:0]  wAddr;
  logic [255:0] wData;
  logic [8:0]   bAddr;
  logic [15:0]  bData;

  logic         gStart = 1'b0, gValid = 1'b0;
  logic [7:0]   gData = '0;
  logic         gReady, gWWe, gBWe, gDone, gErr;
  logic [10:0]  gWAddr;
  logic [255:0] gWData;
  logic [8:0]   gBAddr;
  logic [15:0]  gBData;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  lstm_init_packer #(.WEIGHT_DEPTH(WD), .BIAS_DEPTH(BD)) dut (
    .clk(clk), .reset(reset), .iStart(start), .iInit_valid(valid), .iInit_data(data),
    .oInit_ready(ready), .oWeight_we(wWe), .oWeight_addr(wAddr), .oWeight_wdata(wData),
    .oBias_we(bWe), .oBias_addr(bAddr), .oBias_wdata(bData), .oInit_done(done), .oError(err)
  );

  lstm_init_packer dutBig (
    .clk(clk), .reset(reset), .iStart(gStart), .iInit_valid(gValid), .iInit_data(gData),
    .oInit_ready(gReady), .oWeight_we(gWWe), .oWeight_addr(gWAddr), .oWeight_wdata(gWData),
    .oBias_we(gBWe), .oBias_addr(gBAddr), .oBias_wdata(gBData), .oInit_done(gDone), .oError(gErr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned  t;
    int unsigned  addr;
    logic [255:0] d;
  } wr_t;

  wr_t gotW[$];
  wr_t gotB[$];
  logic [7:0]  stream [NB];
  int unsigned accT [NB];

  always @(negedge clk) begin
    wr_t r;
    if (wWe) begin
      r.t = cyc; r.addr = 32'(wAddr); r.d = wData;
      gotW.push_back(r);
    end
    if (bWe) begin
      r.t = cyc; r.addr = 32'(bAddr); r.d = 256'(bData);
      gotB.push_back(r);
    end
  end

  int unsigned gW = 0, gB = 0, gOrderBad = 0, gDoneRise = 0;
  logic        gDonePrev = 1'b0;
  logic [10:0] gLastW = '0;
  logic [8:0]  gLastB = '0;
  logic [15:0] gLastBData = '0;
  always @(negedge clk) begin
    if (gWWe) begin
      if (gWAddr != 11'(gW)) gOrderBad++;
      gLastW = gWAddr;
      gW++;
    end
    if (gBWe) begin
      if (gBAddr != 9'(gB)) gOrderBad++;
      gLastB = gBAddr;
      gLastBData = gBData;
      gB++;
    end
    if (gDone && !gDonePrev) gDoneRise++;
    gDonePrev = gDone;
  end

  // Present one byte until accepted (bounded); acc is the cycle in which it was taken.
  task automatic pushByte(input logic [7:0] d, input logic st, output int unsigned acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    valid = 1'b1;
    data = d;
    start = st;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (ready) begin
        acc = cyc;
        ok = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (ok) break;
    end
    valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runLoad(input string name, input int mode, input bit ramp, input int stIdx);
    bit          ok;
    int          gaps;
    int unsigned s, tA;
    logic [255:0] expW;
    logic [15:0]  expB;
    for (int i = 0; i < NB; i++) stream[i] = ramp ? 8'(i) : 8'($urandom);
    gotW.delete();
    gotB.delete();
    pulseStart();
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s start_state ready=%b done=%b expected ready=1 done=0", name, ready, done);
    end
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++) begin
      gaps = (mode == 1) ? ((i > 0) ? 1 : 0) : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin @(posedge clk); #1; end
      pushByte(stream[i], (i == stIdx), accT[i], ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL %s accept_timeout byte=%0d", name, i);
        return;
      end
    end
`ifdef LSTM_INIT_CHECKSUM_EN
    s = 0;
    for (int i = 0; i < NB; i++) s += stream[i];
    pushByte(8'(s), 1'b0, tA, ok);
    if (ok) pushByte(8'(s >> 8), 1'b0, tA, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s check_byte_timeout", name);
    end
`else
    s = 0;
    tA = 0;
`endif
    @(negedge clk);
    total++;
    if (done !== 1'b1 || ready !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s done_rise done=%b ready=%b err=%b expected 1/0/0", name, done, ready, err);
    end
    @(posedge clk); #1;
    total++;
    if (gotW.size() != WD || gotB.size() != BD) begin
      bad++;
      $display("FAIL %s write_count w=%0d b=%0d expected w=%0d b=%0d", name, gotW.size(), gotB.size(), WD, BD);
    end
    for (int w = 0; w < WD && w < gotW.size(); w++) begin
      expW = '0;
      for (int k = 0; k < 32; k++) expW[8*k +: 8] = stream[32*w + k];
      total++;
      if (gotW[w].addr != w || gotW[w].d !== expW) begin
        bad++;
        $display("FAIL %s weight%0d addr=%0d data=%h expected addr=%0d data=%h", name, w, gotW[w].addr, gotW[w].d, w, expW);
      end
      total++;
      if (gotW[w].t != accT[32*w + 31] + 1) begin
        bad++;
        $display("FAIL %s weight%0d_timing strobe=%0d expected=%0d", name, w, gotW[w].t, accT[32*w + 31] + 1);
      end
    end
    for (int b = 0; b < BD && b < gotB.size(); b++) begin
      expB = {stream[32*WD + 2*b + 1], stream[32*WD + 2*b]};
      total++;
      if (gotB[b].addr != b || gotB[b].d !== 256'(expB)) begin
        bad++;
        $display("FAIL %s bias%0d addr=%0d data=%h expected addr=%0d data=%h", name, b, gotB[b].addr, gotB[b].d[15:0], b, expB);
      end
      total++;
      if (gotB[b].t != accT[32*WD + 2*b + 1] + 1) begin
        bad++;
        $display("FAIL %s bias%0d_timing strobe=%0d expected=%0d", name, b, gotB[b].t, accT[32*WD + 2*b + 1] + 1);
      end
    end
  endtask

  // Present bytes while the DUT is not ready: nothing may be consumed or written.
  task automatic presentIgnored(input string name, input logic expDone);
    int unsigned nw;
    nw = gotW.size() + gotB.size();
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      data = 8'($urandom);
      @(negedge clk);
      total++;
      if (ready !== 1'b0 || done !== expDone) begin
        bad++;
        $display("FAIL %s ready=%b done=%b expected ready=0 done=%b", name, ready, done, expDone);
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (gotW.size() + gotB.size() != nw) begin
      bad++;
      $display("FAIL %s stray_writes got=%0d expected=%0d", name, gotW.size() + gotB.size(), nw);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    total++;
    if (ready !== 1'b0 || wWe !== 1'b0 || wAddr !== '0 || wData !== '0 || bWe !== 1'b0 ||
        bAddr !== '0 || bData !== '0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s reset_values ready=%b wwe=%b waddr=%h wdata=%h bwe=%b baddr=%h bdata=%h done=%b err=%b expected all zero",
               name, ready, wWe, wAddr, wData, bWe, bAddr, bData, done, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetOutputs("power_on");
    total++;
    if (gReady !== 1'b0 || gDone !== 1'b0 || gErr !== 1'b0) begin
      bad++;
      $display("FAIL big_reset ready=%b done=%b err=%b expected 0/0/0", gReady, gDone, gErr);
    end
    @(posedge clk); #1;
    presentIgnored("idle_bytes", 1'b0);
  endtask

  task automatic test_mid_reset();
    bit ok;
    int unsigned tA;
    gotW.delete();
    gotB.delete();
    pulseStart();
    for (int i = 0; i < 40; i++) begin
      pushByte(8'($urandom), 1'b0, tA, ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL mid_reset accept_timeout byte=%0d", i);
        return;
      end
    end
    valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkResetOutputs("mid_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (gotW.size() != 1 || gotB.size() != 0) begin
      bad++;
      $display("FAIL mid_reset writes w=%0d b=%0d expected w=1 b=0", gotW.size(), gotB.size());
    end
    presentIgnored("after_reset", 1'b0);
    runLoad("reload_after_reset", 0, 1'b1, -1);
  endtask

  task automatic test_ignore();
    runLoad("start_mid_weight", 0, 1'b0, 10);
    presentIgnored("done_bytes", 1'b1);
    runLoad("start_mid_bias", 2, 1'b0, 32*WD + 1);
  endtask

`ifdef LSTM_INIT_CHECKSUM_EN
  task automatic test_checksum_error();
    bit ok;
    int unsigned s, tA;
    s = 0;
    pulseStart();
    for (int i = 0; i < NB; i++) begin
      stream[i] = 8'($urandom);
      s += stream[i];
      pushByte(stream[i], 1'b0, tA, ok);
    end
    pushByte(8'(s + 1), 1'b0, tA, ok);
    pushByte(8'(s >> 8), 1'b0, tA, ok);
    @(negedge clk);
    total++;
    if (err !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL checksum_mismatch err=%b done=%b ready=%b expected 1/0/0", err, done, ready);
    end
    @(posedge clk); #1;
    pulseStart();
    @(negedge clk);
    total++;
    if (err !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL error_clear err=%b ready=%b expected 0/1", err, ready);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_full_default();
    int unsigned n, sum;
    logic [7:0] prev, last;
    n = 0; sum = 0; prev = '0; last = '0;
    gStart = 1'b1;
    @(posedge clk); #1;
    gStart = 1'b0;
    gValid = 1'b1;
    gData = 8'($urandom);
    for (int c = 0; c < BIG_NB + 100 && n < BIG_NB; c++) begin
      @(negedge clk);
      if (gReady) begin
        prev = last;
        last = gData;
        sum += gData;
        n++;
      end
      @(posedge clk); #1;
      gData = 8'($urandom);
    end
`ifdef LSTM_INIT_CHECKSUM_EN
    for (int j = 0; j < 2; j++) begin
      gData = (j == 0) ? 8'(sum) : 8'(sum >> 8);
      @(posedge clk); #1;
    end
`endif
    gValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (n != BIG_NB) begin
      bad++;
      $display("FAIL full_bytes accepted=%0d expected=%0d", n, BIG_NB);
    end
    total++;
    if (gW != 2048 || gLastW != 11'd2047) begin
      bad++;
      $display("FAIL full_weight count=%0d last=%0d expected count=2048 last=2047", gW, gLastW);
    end
    total++;
    if (gB != 512 || gLastB != 9'd511) begin
      bad++;
      $display("FAIL full_bias count=%0d last=%0d expected count=512 last=511", gB, gLastB);
    end
    total++;
    if (gOrderBad != 0) begin
      bad++;
      $display("FAIL full_addr_order errors=%0d expected=0", gOrderBad);
    end
    total++;
    if (gLastBData !== {last, prev}) begin
      bad++;
      $display("FAIL full_last_bias data=%h expected=%h", gLastBData, {last, prev});
    end
    total++;
    if (gDone !== 1'b1 || gDoneRise != 1 || gErr !== 1'b0) begin
      bad++;
      $display("FAIL full_done done=%b rises=%0d err=%b expected 1/1/0", gDone, gDoneRise, gErr);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    runLoad("ramp_full_rate", 0, 1'b1, -1);
    runLoad("ramp_alternate", 1, 1'b1, -1);
    runLoad("random_gaps", 2, 1'b0, -1);
    test_mid_reset();
    test_ignore();
`ifdef LSTM_INIT_CHECKSUM_EN
    test_checksum_error();
`endif
    test_full_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
